// File: rtl/membus_pkg.sv
// membus_pkg: shared FSM state type and packed-vector slice helper for the membus_ws interconnect.
package membus_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  function automatic int win_lo(input int i, input int w);
    return i * w;
  endfunction
endpackage

// File: rtl/membus_decode.sv
// membus_decode: combinational address-window matcher with lowest-index priority.
//   i_addr  master address
//   o_hit   one-hot winning window (lowest matching index)
//   o_miss  no window matched
module membus_decode import membus_pkg::*; #(
  parameter int AW = 9,
  parameter int N = 4,
  parameter logic [N*AW-1:0] BASE = '0,
  parameter logic [N*AW-1:0] MASK = '0
) (
  input  logic [AW-1:0] i_addr,
  output logic [N-1:0]  o_hit,
  output logic          o_miss
);
  logic [N-1:0] w_match;
  for (genvar g = 0; g < N; g++) begin : g_win
    assign w_match[g] = ((i_addr ^ BASE[win_lo(g, AW) +: AW]) & MASK[win_lo(g, AW) +: AW]) == '0;
  end
  // x & -x isolates the lowest set bit, so overlapping windows resolve to the lowest index
  assign o_hit  = w_match & (~w_match + N'(1));
  assign o_miss = ~|w_match;
endmodule

// File: rtl/membus_ws.sv
// membus_ws: single-master memory-bus interconnect with wait states, bus error and timeout.
//   clk, reset                 clock, async active-high reset
//   m_req/m_write/m_addr/m_wdata  master request, held until m_ready
//   m_ready/m_err/m_rdata      one-cycle registered completion with error flag and read data
//   s_sel/s_write/s_addr/s_wdata  registered one-hot select and request copy to slaves
//   s_ready/s_rdata            per-slave completion and read data
module membus_ws import membus_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int ADDR_WIDTH = 9,
  parameter int NSLAVES = 4,
  parameter logic [NSLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = '0,
  parameter logic [NSLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = '0,
  parameter int TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     m_req,
  input  logic                     m_write,
  input  logic [ADDR_WIDTH-1:0]    m_addr,
  input  logic [WIDTH-1:0]         m_wdata,
  output logic                     m_ready,
  output logic                     m_err,
  output logic [WIDTH-1:0]         m_rdata,
  output logic [NSLAVES-1:0]       s_sel,
  output logic                     s_write,
  output logic [ADDR_WIDTH-1:0]    s_addr,
  output logic [WIDTH-1:0]         s_wdata,
  input  logic [NSLAVES-1:0]       s_ready,
  input  logic [NSLAVES*WIDTH-1:0] s_rdata
);
  // a zero-width counter is illegal, so TIMEOUT=0 still gets one (unused) bit
  localparam int CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO = CW'(TIMEOUT);
  state_t r_state, w_next;
  logic [NSLAVES-1:0] w_hit, r_sel;
  logic w_miss, w_sel_ready, w_timeout, w_err, w_accept;
  logic r_ready, r_err, r_write;
  logic [WIDTH-1:0] w_rdata, r_rdata, r_wdata;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [CW-1:0] r_cnt;
  membus_decode #(.AW(ADDR_WIDTH), .N(NSLAVES), .BASE(SLAVE_BASE), .MASK(SLAVE_MASK)) u_dec (
    .i_addr(m_addr),
    .o_hit (w_hit),
    .o_miss(w_miss)
  );
  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < NSLAVES; i++) w_rdata |= r_sel[i] ? s_rdata[win_lo(i, WIDTH) +: WIDTH] : '0;
    w_sel_ready = |(r_sel & s_ready);
    w_timeout = (TIMEOUT != 0) && (r_cnt == TO);
    w_accept = (r_state == IDLE) && m_req && !w_miss;
    w_next = (r_state == IDLE)   ? (m_req ? (w_miss ? RESP : ACCESS) : IDLE) :
             (r_state == ACCESS) ? ((w_sel_ready || w_timeout) ? RESP : ACCESS) : IDLE;
    // a ready arriving in the timeout cycle still completes successfully
    w_err = (r_state == IDLE) ? w_miss : !w_sel_ready;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
      r_sel   <= '0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_ready <= w_next == RESP;
      r_err   <= (w_next == RESP) && w_err;
      if (w_next == RESP) r_rdata <= (!w_err && !r_write) ? w_rdata : '0;
      if (w_accept) begin
        r_sel   <= w_hit;
        r_write <= m_write;
        r_addr  <= m_addr;
        r_wdata <= m_wdata;
        r_cnt   <= '0;
      end else if (r_state == ACCESS) begin
        if (w_next == RESP) r_sel <= '0;
        else if (r_cnt != '1) r_cnt <= r_cnt + CW'(1);
      end
    end
  end
  assign m_ready = r_ready;
  assign m_err   = r_err;
  assign m_rdata = r_rdata;
  assign s_sel   = r_sel;
  assign s_write = r_write;
  assign s_addr  = r_addr;
  assign s_wdata = r_wdata;
endmodule

// File: tb/tb_membus_ws.sv
// tb_membus_ws: directed bench for membus_ws; dut_a has four disjoint windows and TIMEOUT=15, dut_b overlaps slave2 over everything with TIMEOUT=0.
module tb_membus_ws;
  logic clk = 1'b0, reset = 1'b1, m_req = 1'b0, m_write = 1'b0;
  logic [8:0] m_addr = '0;
  logic [15:0] m_wdata = '0;
  logic [3:0] s_ready = '0;
  logic [63:0] s_rdata = '0;
  logic a_ready, a_err, a_write, b_ready, b_err, b_write;
  logic [15:0] a_rdata, a_wdata, b_rdata, b_wdata;
  logic [3:0] a_sel, b_sel;
  logic [8:0] a_addr, b_addr;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  membus_ws #(.WIDTH(16), .ADDR_WIDTH(9), .NSLAVES(4),
    .SLAVE_BASE({9'h1C0, 9'h180, 9'h100, 9'h000}),
    .SLAVE_MASK({9'h1F0, 9'h1C0, 9'h1FE, 9'h100}), .TIMEOUT(15)) dut_a (
    .clk(clk), .reset(reset), .m_req(m_req), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(a_ready), .m_err(a_err), .m_rdata(a_rdata), .s_sel(a_sel), .s_write(a_write),
    .s_addr(a_addr), .s_wdata(a_wdata), .s_ready(s_ready), .s_rdata(s_rdata));
  membus_ws #(.WIDTH(16), .ADDR_WIDTH(9), .NSLAVES(4),
    .SLAVE_BASE({9'h1C0, 9'h000, 9'h100, 9'h000}),
    .SLAVE_MASK({9'h1F0, 9'h000, 9'h1FE, 9'h100}), .TIMEOUT(0)) dut_b (
    .clk(clk), .reset(reset), .m_req(m_req), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(b_ready), .m_err(b_err), .m_rdata(b_rdata), .s_sel(b_sel), .s_write(b_write),
    .s_addr(b_addr), .s_wdata(b_wdata), .s_ready(s_ready), .s_rdata(s_rdata));
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic req(input logic w, input logic [8:0] a, input logic [15:0] d);
    m_req = 1'b1;
    m_write = w;
    m_addr = a;
    m_wdata = d;
  endtask
  task automatic do_reset;
    reset = 1'b1;
    m_req = 1'b0;
    s_ready = '0;
    step;
    reset = 1'b0;
    step;
  endtask
  task automatic test_reset;
    reset = 1'b1;
    step;
    step;
    total++;
    if ({a_sel, a_ready, a_err, a_rdata, a_write, a_addr, a_wdata} !== '0) begin
      bad++;
      $display("FAIL reset_a got sel=%b rdy=%b err=%b rd=%h w=%b a=%h wd=%h want all 0", a_sel, a_ready, a_err, a_rdata, a_write, a_addr, a_wdata);
    end
    total++;
    if ({b_sel, b_ready, b_err, b_rdata, b_write, b_addr, b_wdata} !== '0) begin
      bad++;
      $display("FAIL reset_b got sel=%b rdy=%b err=%b rd=%h want all 0", b_sel, b_ready, b_err, b_rdata);
    end
    reset = 1'b0;
    step;
  endtask
  task automatic test_read;
    do_reset;
    s_rdata[15:0] = 16'hBEEF;
    req(1'b0, 9'h042, 16'h0);
    step;
    total++;
    if ({a_sel, a_ready} !== {4'b0001, 1'b0}) begin
      bad++;
      $display("FAIL read_c1 got sel=%b rdy=%b want sel=0001 rdy=0", a_sel, a_ready);
    end
    step;
    total++;
    if ({a_ready, a_write, a_addr} !== {1'b0, 1'b0, 9'h042}) begin
      bad++;
      $display("FAIL read_c2 got rdy=%b w=%b addr=%h want 0 0 042", a_ready, a_write, a_addr);
    end
    s_ready = 4'b0001;
    step;
    s_ready = '0;
    m_req = 1'b0;
    total++;
    if ({a_ready, a_err, a_rdata, a_sel} !== {1'b1, 1'b0, 16'hBEEF, 4'b0000}) begin
      bad++;
      $display("FAIL read_done got rdy=%b err=%b rd=%h sel=%b want 1 0 beef 0000", a_ready, a_err, a_rdata, a_sel);
    end
    step;
    total++;
    if (a_ready !== 1'b0) begin
      bad++;
      $display("FAIL read_pulse got rdy=%b want 0", a_ready);
    end
  endtask
  task automatic test_write;
    do_reset;
    s_rdata[31:16] = 16'h1234;
    req(1'b1, 9'h101, 16'h00A5);
    step;
    for (int c = 1; c <= 4; c++) begin
      total++;
      if ({a_sel, a_write, a_wdata, a_addr, a_ready} !== {4'b0010, 1'b1, 16'h00A5, 9'h101, 1'b0}) begin
        bad++;
        $display("FAIL write_c%0d got sel=%b w=%b wd=%h a=%h rdy=%b want 0010 1 00a5 101 0", c, a_sel, a_write, a_wdata, a_addr, a_ready);
      end
      if (c == 4) s_ready = 4'b0010;
      step;
    end
    s_ready = '0;
    m_req = 1'b0;
    total++;
    if ({a_ready, a_err, a_rdata, a_sel} !== {1'b1, 1'b0, 16'h0000, 4'b0000}) begin
      bad++;
      $display("FAIL write_done got rdy=%b err=%b rd=%h sel=%b want 1 0 0000 0000", a_ready, a_err, a_rdata, a_sel);
    end
  endtask
  task automatic test_unmapped;
    do_reset;
    s_rdata = {4{16'hFFFF}};
    req(1'b0, 9'h1F0, 16'h0);
    step;
    m_req = 1'b0;
    total++;
    if ({a_ready, a_err, a_rdata, a_sel} !== {1'b1, 1'b1, 16'h0000, 4'b0000}) begin
      bad++;
      $display("FAIL unmapped got rdy=%b err=%b rd=%h sel=%b want 1 1 0000 0000", a_ready, a_err, a_rdata, a_sel);
    end
    total++;
    if ({b_sel, b_ready} !== {4'b0100, 1'b0}) begin
      bad++;
      $display("FAIL overlap_catchall got sel=%b rdy=%b want 0100 0", b_sel, b_ready);
    end
    step;
    total++;
    if ({a_ready, a_err} !== 2'b00) begin
      bad++;
      $display("FAIL unmapped_pulse got rdy=%b err=%b want 0 0", a_ready, a_err);
    end
  endtask
  task automatic test_timeout;
    int stuck;
    do_reset;
    s_rdata = '0;
    req(1'b0, 9'h042, 16'h0);
    step;
    for (int c = 1; c <= 16; c++) begin
      total++;
      if ({a_sel, a_ready} !== {4'b0001, 1'b0}) begin
        bad++;
        $display("FAIL timeout_c%0d got sel=%b rdy=%b want 0001 0", c, a_sel, a_ready);
      end
      step;
    end
    m_req = 1'b0;
    total++;
    if ({a_ready, a_err, a_rdata, a_sel} !== {1'b1, 1'b1, 16'h0000, 4'b0000}) begin
      bad++;
      $display("FAIL timeout_done got rdy=%b err=%b rd=%h sel=%b want 1 1 0000 0000", a_ready, a_err, a_rdata, a_sel);
    end
    stuck = 0;
    for (int c = 0; c < 24; c++) begin
      if ({b_sel, b_ready} === {4'b0001, 1'b0}) stuck++;
      step;
    end
    total++;
    if (stuck !== 24) begin
      bad++;
      $display("FAIL notimeout_wait got cycles_waiting=%0d want 24", stuck);
    end
    s_rdata[15:0] = 16'h5151;
    s_ready = 4'b0001;
    step;
    s_ready = '0;
    total++;
    if ({b_ready, b_err, b_rdata, b_sel} !== {1'b1, 1'b0, 16'h5151, 4'b0000}) begin
      bad++;
      $display("FAIL notimeout_done got rdy=%b err=%b rd=%h sel=%b want 1 0 5151 0000", b_ready, b_err, b_rdata, b_sel);
    end
  endtask
  task automatic test_overlap_stray;
    do_reset;
    s_rdata = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    req(1'b0, 9'h042, 16'h0);
    step;
    total++;
    if (b_sel !== 4'b0001) begin
      bad++;
      $display("FAIL overlap_lowest got sel=%b want 0001", b_sel);
    end
    s_ready = 4'b0001;
    step;
    s_ready = '0;
    m_req = 1'b0;
    total++;
    if ({b_ready, b_err, b_rdata} !== {1'b1, 1'b0, 16'h1111}) begin
      bad++;
      $display("FAIL overlap_done got rdy=%b err=%b rd=%h want 1 0 1111", b_ready, b_err, b_rdata);
    end
    step;
    req(1'b0, 9'h100, 16'h0);
    step;
    s_ready = 4'b1101;
    step;
    total++;
    if ({a_ready, a_sel} !== {1'b0, 4'b0010}) begin
      bad++;
      $display("FAIL stray_ignored got rdy=%b sel=%b want 0 0010", a_ready, a_sel);
    end
    s_ready = 4'b0010;
    step;
    s_ready = '0;
    m_req = 1'b0;
    total++;
    if ({a_ready, a_err, a_rdata} !== {1'b1, 1'b0, 16'h2222}) begin
      bad++;
      $display("FAIL stray_done got rdy=%b err=%b rd=%h want 1 0 2222", a_ready, a_err, a_rdata);
    end
  endtask
  task automatic test_back_to_back;
    do_reset;
    s_rdata[31:0] = {16'hD00D, 16'hCAFE};
    req(1'b0, 9'h000, 16'h0);
    s_ready = 4'b0001;
    step;
    total++;
    if (a_sel !== 4'b0001) begin
      bad++;
      $display("FAIL b2b_sel1 got sel=%b want 0001", a_sel);
    end
    step;
    s_ready = '0;
    req(1'b0, 9'h100, 16'h0);
    total++;
    if ({a_ready, a_err, a_rdata} !== {1'b1, 1'b0, 16'hCAFE}) begin
      bad++;
      $display("FAIL b2b_first got rdy=%b err=%b rd=%h want 1 0 cafe", a_ready, a_err, a_rdata);
    end
    step;
    total++;
    if ({a_ready, a_sel} !== {1'b0, 4'b0000}) begin
      bad++;
      $display("FAIL b2b_gap got rdy=%b sel=%b want 0 0000", a_ready, a_sel);
    end
    step;
    total++;
    if (a_sel !== 4'b0010) begin
      bad++;
      $display("FAIL b2b_sel2 got sel=%b want 0010", a_sel);
    end
    s_ready = 4'b0010;
    step;
    s_ready = '0;
    m_req = 1'b0;
    total++;
    if ({a_ready, a_err, a_rdata} !== {1'b1, 1'b0, 16'hD00D}) begin
      bad++;
      $display("FAIL b2b_second got rdy=%b err=%b rd=%h want 1 0 d00d", a_ready, a_err, a_rdata);
    end
  endtask
  task automatic test_reset_mid;
    do_reset;
    req(1'b1, 9'h100, 16'h5A5A);
    step;
    step;
    total++;
    if ({a_sel, a_wdata} !== {4'b0010, 16'h5A5A}) begin
      bad++;
      $display("FAIL midrst_pre got sel=%b wd=%h want 0010 5a5a", a_sel, a_wdata);
    end
    reset = 1'b1;
    #1;
    total++;
    if ({a_sel, a_ready, a_err, a_rdata, a_write, a_addr, a_wdata, b_sel, b_write, b_wdata} !== '0) begin
      bad++;
      $display("FAIL midrst_async got sel=%b w=%b a=%h wd=%h bsel=%b want all 0", a_sel, a_write, a_addr, a_wdata, b_sel);
    end
    m_req = 1'b0;
    step;
    reset = 1'b0;
    s_rdata[15:0] = 16'h7777;
    req(1'b0, 9'h042, 16'h0);
    step;
    s_ready = 4'b0001;
    step;
    s_ready = '0;
    m_req = 1'b0;
    total++;
    if ({a_ready, a_err, a_rdata} !== {1'b1, 1'b0, 16'h7777}) begin
      bad++;
      $display("FAIL midrst_fresh got rdy=%b err=%b rd=%h want 1 0 7777", a_ready, a_err, a_rdata);
    end
  endtask
  initial begin
    test_reset;
    test_read;
    test_write;
    test_unmapped;
    test_timeout;
    test_overlap_stray;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
